// File: rtl/multdiv_step_counter.sv
// Purpose : loadable down-counting iteration sequencer; on start it issues N
//           consecutive step cycles, then a single done pulse.
// Latency : done appears N+1 cycles after start is accepted (1 cycle for N = 0).
// Backpressure: none; start is ignored while running, abort wins over start.
//
// Ports:
//   clock       - rising-edge clock
//   clear_n     - asynchronous active-low reset
//   start       - request a new operation (accepted in IDLE or DONE)
//   count_init  - iteration count N, captured with an accepted start
//   abort       - cancel a running operation, also blocks a start
//   busy / step - high while iterating
//   count       - remaining iterations including the current one
//   done        - one-cycle completion pulse
module multdiv_step_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic [WIDTH-1:0] count_init,
    input  logic             abort,
    output logic             busy,
    output logic             step,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             accept;

    // Abort has priority over start in every state that listens to start.
    assign accept = start & ~abort;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            // DONE behaves like IDLE for new requests so operations can
            // run back to back without an idle gap.
            IDLE, DONE: begin
                if (accept) begin
                    if (count_init == '0) begin
                        // Zero-length operation: report completion, no steps.
                        state_nxt = DONE;
                        count_nxt = '0;
                    end else begin
                        state_nxt = RUN;
                        count_nxt = count_init;
                    end
                end else begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    // Cancelled work never reports done, even on the last step.
                    state_nxt = IDLE;
                    count_nxt = '0;
                end else if (count == WIDTH'(1)) begin
                    state_nxt = DONE;
                    count_nxt = '0;
                end else begin
                    state_nxt = RUN;
                    count_nxt = count - WIDTH'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    // All outputs are decoded from registered state only.
    assign busy = (state == RUN);
    assign step = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_multdiv_step_counter.sv
module tb_multdiv_step_counter;

    localparam int W = 6;

    logic         clock = 1'b0;
    logic         clear_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] count_init = '0;
    logic         busy;
    logic         step;
    logic [W-1:0] count;
    logic         done;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    multdiv_step_counter #(.WIDTH(W)) dut (
        .clock      (clock),
        .clear_n    (clear_n),
        .start      (start),
        .count_init (count_init),
        .abort      (abort),
        .busy       (busy),
        .step       (step),
        .count      (count),
        .done       (done)
    );

    always #5 clock = ~clock;

    // Reference model: a schedule of upcoming cycles. An accepted start
    // appends N stepping cycles (N..1) followed by one done cycle.
    // Encoding: >0 stepping with that count, -1 done, 0 idle.
    int sched[$];
    int cur = 0;

    always @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            sched.delete();
            cur = 0;
        end else begin
            if (cur > 0 && abort) begin
                sched.delete();
            end else if (cur <= 0 && start && !abort) begin
                sched.delete();
                for (int i = int'(count_init); i >= 1; i--) sched.push_back(i);
                sched.push_back(-1);
            end
            if (sched.size() > 0) cur = sched.pop_front();
            else cur = 0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (chk_en) begin
            logic [W+2:0] exp_v;
            logic [W+2:0] got_v;
            exp_v = {cur > 0, cur > 0, cur == -1, (cur > 0) ? W'(cur) : W'(0)};
            got_v = {busy, step, done, count};
            n_total++;
            if (got_v === exp_v) n_pass++;
            else $display("FAIL model_cycle t=%0t got busy/step/done/count=%b required=%b",
                          $time, got_v, exp_v);
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d required=%0d", name, got, exp);
    endtask

    // Drive inputs on the falling edge, then settle just after the rising edge.
    task automatic run_cycle(input bit s, input bit a, input int n);
        @(negedge clock);
        start = s;
        abort = a;
        count_init = W'(n);
        @(posedge clock);
        #1;
    endtask

    task automatic measure(input int n, output int steps, output int dones, output int lat);
        steps = 0;
        dones = 0;
        lat = -1;
        run_cycle(1'b1, 1'b0, n);
        for (int c = 1; c <= 200; c++) begin
            if (step) steps++;
            if (done) begin
                dones++;
                lat = c;
                break;
            end
            run_cycle(1'b0, 1'b0, 0);
        end
        run_cycle(1'b0, 1'b0, 0);
        if (done) dones++;
    endtask

    initial begin
        int steps, dones, lat;
        logic [9:0] stepv, donev;

        #1;
        check("reset_during_clear", {busy, step, done, count}, 0);
        repeat (2) @(negedge clock);
        clear_n = 1'b1;
        chk_en = 1'b1;
        run_cycle(1'b0, 1'b0, 0);
        check("idle_after_reset", {busy, step, done, count}, 0);

        // Normal run, N = 32.
        measure(32, steps, dones, lat);
        check("n32_steps", steps, 32);
        check("n32_dones", dones, 1);
        check("n32_latency", lat, 33);
        check("n32_idle_after", {busy, done, count}, 0);

        // Zero-length.
        measure(0, steps, dones, lat);
        check("n0_steps", steps, 0);
        check("n0_latency", lat, 1);
        check("n0_dones", dones, 1);

        // Maximum count.
        measure(63, steps, dones, lat);
        check("n63_steps", steps, 63);
        check("n63_latency", lat, 64);

        // Abort after 4 steps.
        run_cycle(1'b1, 1'b0, 10);
        repeat (3) run_cycle(1'b0, 1'b0, 0);
        check("abort4_count_before", count, 7);
        run_cycle(1'b0, 1'b1, 0);
        check("abort4_state", {busy, step, done, count}, 0);
        run_cycle(1'b0, 1'b0, 0);
        check("abort4_no_done", done, 0);

        // Abort on the last step.
        run_cycle(1'b1, 1'b0, 10);
        repeat (9) run_cycle(1'b0, 1'b0, 0);
        check("abort_last_count", count, 1);
        run_cycle(1'b0, 1'b1, 0);
        check("abort_last_state", {busy, step, done, count}, 0);
        run_cycle(1'b0, 1'b0, 0);
        check("abort_last_no_done", done, 0);

        // Back-to-back with an ignored start during RUN.
        stepv = '0;
        donev = '0;
        run_cycle(1'b1, 1'b0, 5);
        for (int c = 0; c < 10; c++) begin
            stepv[c] = step;
            donev[c] = done;
            if (c == 1) run_cycle(1'b1, 1'b0, 7);
            else if (c == 5 && done) run_cycle(1'b1, 1'b0, 3);
            else run_cycle(1'b0, 1'b0, 0);
        end
        check("b2b_step_pattern", int'(stepv), 'h1DF);
        check("b2b_done_pattern", int'(donev), 'h220);
        check("b2b_idle_after", {busy, done}, 0);

        // start and abort together in IDLE.
        run_cycle(1'b1, 1'b1, 9);
        check("start_abort_idle", {busy, step, done, count}, 0);
        run_cycle(1'b0, 1'b0, 0);
        check("start_abort_stays", {busy, done}, 0);

        // Asynchronous reset mid-run, N = 20 after 5 steps.
        run_cycle(1'b1, 1'b0, 20);
        repeat (5) run_cycle(1'b0, 1'b0, 0);
        check("rst_count_before", count, 15);
        #2;
        clear_n = 1'b0;
        #1;
        check("rst_immediate", {busy, step, done, count}, 0);
        repeat (2) @(negedge clock);
        clear_n = 1'b1;
        repeat (3) run_cycle(1'b0, 1'b0, 0);
        check("rst_stays_idle", {busy, step, done, count}, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit s, a;
            int n;
            s = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 15) == 0);
            n = ($urandom_range(0, 19) == 0) ? 63 : int'($urandom_range(0, 12));
            run_cycle(s, a, n);
        end
        run_cycle(1'b0, 1'b0, 0);

        @(negedge clock);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule
